// File: rtl/alu_pkg.sv
// Shared opcode encodings for the pipelined ALU and its combinational core.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: (opcode, a, b) -> (result, zero, carry/borrow, overflow).
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             v
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   amt;
  logic             shift_oob;

  assign sum       = {1'b0, a} + {1'b0, b};
  assign diff      = {1'b0, a} - {1'b0, b};
  assign amt       = b[SHW-1:0];
  assign shift_oob = (int'(amt) >= WIDTH);

  // diff[WIDTH] is the borrow, i.e. set exactly when a < b unsigned
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (opcode)
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        c      = diff[WIDTH];
        v      = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = shift_oob ? '0 : (a << amt);
      OP_SHR:  result = shift_oob ? '0 : (a >> amt);
      default: result = '0;
    endcase
  end

  assign z = (result == '0);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with an optional accumulator feeding operand A.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v
);

  logic             s1_valid_q, s1_valid_d;
  logic [2:0]       s1_opcode_q, s1_opcode_d;
  logic             s1_acc_sel_q, s1_acc_sel_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_v_q, flag_v_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s2_free;
  logic             xfer;
  logic             accept;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] core_result;
  logic             core_z, core_c, core_v;

  assign s2_free  = !out_valid_q || out_ready;
  assign xfer     = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  // Accumulator is read at transfer time, so a chained op sees the previous op's result.
  assign a_eff = s1_acc_sel_q ? acc_q : s1_a_q;

  alu_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .opcode (s1_opcode_q),
    .a      (a_eff),
    .b      (s1_b_q),
    .result (core_result),
    .z      (core_z),
    .c      (core_c),
    .v      (core_v)
  );

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_opcode_d  = s1_opcode_q;
    s1_acc_sel_d = s1_acc_sel_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    out_valid_d  = out_valid_q;
    result_d     = result_q;
    flag_z_d     = flag_z_q;
    flag_c_d     = flag_c_q;
    flag_v_d     = flag_v_q;
    acc_d        = acc_q;

    if (accept) begin
      s1_valid_d   = 1'b1;
      s1_opcode_d  = opcode;
      s1_acc_sel_d = acc_sel;
      s1_a_d       = a;
      s1_b_d       = b;
    end else if (xfer) begin
      s1_valid_d = 1'b0;
    end

    if (xfer) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      flag_z_d    = core_z;
      flag_c_d    = core_c;
      flag_v_d    = core_v;
      acc_d       = core_result;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_opcode_q  <= '0;
      s1_acc_sel_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      flag_z_q     <= 1'b0;
      flag_c_q     <= 1'b0;
      flag_v_q     <= 1'b0;
      acc_q        <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_opcode_q  <= s1_opcode_d;
      s1_acc_sel_q <= s1_acc_sel_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      flag_z_q     <= flag_z_d;
      flag_c_q     <= flag_c_d;
      flag_v_q     <= flag_v_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_z    = flag_z_q;
  assign flag_c    = flag_c_q;
  assign flag_v    = flag_v_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe with an in-order expected-result queue.
module tb_alu_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic             acc_sel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z, flag_c, flag_v;

  alu_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .acc_sel   (acc_sel),
    .a         (a),
    .b         (b),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic       use_model;
    logic [2:0] op;
    logic       acc_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] model_acc = 8'h00;

  // Reference model in plain integer arithmetic; returns {v, c, z, res}.
  function automatic logic [10:0] model_alu(input logic [2:0] op, input logic [7:0] ae,
                                            input logic [7:0] bv);
    int ua, ub, sa, sb, s, r;
    logic c, v;
    ua = int'(ae);
    ub = int'(bv);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c  = 1'b0;
    v  = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin
        r = (ua + ub) % 256;
        c = (ua + ub) >= 256;
        s = sa + sb;
        v = (s > 127) || (s < -128);
      end
      3'd1: begin
        r = (ua - ub + 256) % 256;
        c = ua < ub;
        s = sa - sb;
        v = (s > 127) || (s < -128);
      end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = 255 - ua;
      3'd6: r = (ua << (ub % 8)) % 256;
      default: r = ua >> (ub % 8);
    endcase
    return {v, c, (r == 0), r[7:0]};
  endfunction

  beat_t       mon_e;
  logic [10:0] mon_m;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_acc = 8'h00;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.use_model) begin
            mon_m = model_alu(mon_e.op, mon_e.acc_sel ? model_acc : mon_e.a, mon_e.b);
            mon_e.res = mon_m[7:0];
            mon_e.z   = mon_m[8];
            mon_e.c   = mon_m[9];
            mon_e.v   = mon_m[10];
          end
          check_val($sformatf("result[%0d]", pops), result, mon_e.res);
          check_val($sformatf("flag_z[%0d]", pops), flag_z, mon_e.z);
          check_val($sformatf("flag_c[%0d]", pops), flag_c, mon_e.c);
          check_val($sformatf("flag_v[%0d]", pops), flag_v, mon_e.v);
          model_acc = mon_e.res;
          pops++;
        end
      end
      if (acc_clr) model_acc = 8'h00;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is accepted.
  task automatic send(input logic [2:0] op, input logic sel, input logic [7:0] av,
                      input logic [7:0] bv, input logic use_model, input logic [7:0] res,
                      input logic z, input logic c, input logic v);
    beat_t e;
    bit    ok;
    in_valid = 1'b1;
    opcode   = op;
    acc_sel  = sel;
    a        = av;
    b        = bv;
    ok       = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      check_val("in_ready_timeout", 32'd0, 32'd1);
    end else begin
      e = '{use_model, op, sel, av, bv, res, z, c, v};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    check_val(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  bit rand_done;
  int pops_before;
  logic [WIDTH-1:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    opcode    = 3'd0;
    acc_sel   = 1'b0;
    a         = '0;
    b         = '0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_result", result, 0);
    check_val("rst_flags", {flag_z, flag_c, flag_v}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency: accept at edge N, out_valid after edge N+1.
    send(3'd0, 1'b0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_val("lat_1clk_valid", out_valid, 0);
    @(negedge clk);
    check_val("lat_2clk_valid", out_valid, 1);
    @(posedge clk);
    #1;

    send(3'd0, 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    send(3'd1, 1'b0, 8'h05, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    send(3'd1, 1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
    send(3'd6, 1'b0, 8'h81, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    send(3'd7, 1'b0, 8'h80, 8'h09, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
    send(3'd2, 1'b0, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    send(3'd3, 1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    send(3'd4, 1'b0, 8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    send(3'd5, 1'b0, 8'h0F, 8'h33, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    send(3'd1, 1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    send(3'd6, 1'b0, 8'hFF, 8'h07, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
    drain("drain_directed");

    acc_clr = 1'b1;
    @(posedge clk);
    #1 acc_clr = 1'b0;
    send(3'd0, 1'b1, 8'h55, 8'h40, 1'b0, 8'h40, 1'b0, 1'b0, 1'b0);
    send(3'd0, 1'b1, 8'h55, 8'h40, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    send(3'd0, 1'b1, 8'h55, 8'h40, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0);
    send(3'd0, 1'b1, 8'h55, 8'h40, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    drain("drain_acc");

    // Reset while a result is parked at the output.
    out_ready = 1'b0;
    send(3'd0, 1'b0, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_valid", out_valid, 1);
    check_val("pre_rst_result", result, 8'h10);
    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_result", result, 0);
    check_val("mid_rst_flags", {flag_z, flag_c, flag_v}, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", in_ready, 1);
    check_val("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;

    // Backpressure: six beats against a stalled consumer.
    pops_before = pops;
    out_ready   = 1'b0;
    fork
      begin
        send(3'd0, 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        send(3'd1, 1'b0, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        send(3'd4, 1'b0, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
        send(3'd2, 1'b0, 8'hFF, 8'h0F, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0);
        send(3'd6, 1'b0, 8'h01, 8'h07, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0);
        send(3'd3, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      end
      begin
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        check_val("bp_first_valid", out_valid, 1);
        held = result;
        repeat (5) begin
          @(negedge clk);
          check_val("bp_hold_result", result, held);
          check_val("bp_hold_valid", out_valid, 1);
          check_val("bp_in_ready", in_ready, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check_val("bp_count", pops - pops_before, 6);

    // Random stream with random consumer stalls.
    pops_before = pops;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom),
               8'($urandom), 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #0;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain("drain_rand");
    check_val("rand_count", pops - pops_before, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational ALU.
- Operands enter through a valid/ready handshake and pass through two register stages. Results leave through a valid/ready handshake with status flags.
- Optional accumulator mode: operand A is taken from the previous result, so chained operations need no external feedback.
- Sits between an operand source (sequencer or test driver) and a result consumer that may apply backpressure.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- SHW, 3, shift-amount width; shifts use b[SHW-1:0]; require 2**SHW >= WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept an operand beat
- opcode  input  3  operation select, sampled with the beat
- acc_sel  input  1  1 = use accumulator as operand A, ignore a
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- acc_clr  input  1  synchronous clear of accumulator
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- flag_z  output  1  result == 0
- flag_c  output  1  carry out (ADD) / borrow (SUB), else 0
- flag_v  output  1  signed overflow (ADD/SUB), else 0

Behaviour:
- Reset (async, rst_n=0): s1_valid=0, out_valid=0, result=0, all flags=0, acc=0. in_ready=1 once rst_n=1.
- Stage 1 (S1) captures opcode, acc_sel, a, b on in_valid && in_ready.
- Stage 2 (S2, output) loads on S1 -> S2 transfer. The ALU is computed at transfer from S1 contents; result and flags are registered.
- Advance rules:
  - s2_free = !out_valid || out_ready
  - S1 -> S2 transfer when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free (combinational; no dependence on in_valid)
- Latency: 2 clk from input accept to out_valid with no backpressure. Throughput: 1 beat/clk.
- Backpressure: while out_valid && !out_ready, result and flags hold stable. S1 holds; in_ready=0 once S1 is occupied. No beat is lost or duplicated.
- Opcodes (A_eff = acc_sel ? acc : a):
  - 000 ADD: A_eff + b
  - 001 SUB: A_eff - b
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A_eff
  - 110 SHL: A_eff << b[SHW-1:0]
  - 111 SHR logical: A_eff >> b[SHW-1:0]
- Width rules:
  - ADD/SUB computed in WIDTH+1 bits; result = low WIDTH bits (wrap-around).
  - flag_c = bit WIDTH for ADD; for SUB, flag_c = 1 iff A_eff < b unsigned.
  - flag_v: ADD, operands of same sign and result of different sign; SUB, operand signs differ and result sign != A_eff sign.
  - Shift amount >= WIDTH gives 0.
- Accumulator: acc <= new result on every S1 -> S2 transfer, so back-to-back acc_sel ops chain with no hazard.
  - acc_clr sets acc=0 next clk. It takes priority over a simultaneous transfer update.
  - acc_sel read by an op transferring in the same cycle as acc_clr sees the old acc.
- Simultaneous accept at input and output in one clk is allowed; the pipeline stays full.
- Reset mid-operation discards both stages; no partial output.
- opcode/a/b are don't-care when in_valid=0.

Decomposition:
- Shared package alu_pkg: opcode localparams (OP_ADD..OP_SHR, 3-bit).
- Sub-module alu_core: purely combinational (opcode, a, b) -> (result, z, c, v), WIDTH-parametrised. alu_pipe instantiates it between S1 and S2 and holds handshake, accumulator and registers.

Test Plan (WIDTH=8, out_ready=1 unless stated):
- Reset: assert rst_n=0 mid-stream -> out_valid=0, result=0, flags=0 immediately; in_ready=1 after release.
- ADD 0xF0 + 0x20 -> result=0x10, c=1, v=0, z=0, out_valid exactly 2 clk after accept. ADD 0x7F + 0x01 -> 0x80, v=1, c=0.
- SUB 0x05 - 0x05 -> 0x00, z=1, c=0. SUB 0x03 - 0x05 -> 0xFE, c=1. SHL 0x81 by 1 -> 0x02. SHR 0x80 by 9 (b[2:0]=1) -> 0x40.
- Accumulator: acc_clr, then four back-to-back ADD acc_sel=1 with b=0x40 -> results 0x40, 0x80, 0xC0, 0x00 (c=1 on last).
- Backpressure: stream 6 beats, hold out_ready=0 for 5 clk -> result held stable, in_ready=0 once S1 full; release -> all 6 results in order, none dropped or duplicated.
- Random: 30 beats with random a/b/opcode and random out_ready -> outputs match an ALU reference model in order.
